poly_envelope: RTL

POLY_ENVELOPE -- requirements
Module: poly_envelope

---
 rtl/poly_envelope.sv | 137 +++++++++++++
 1 files changed

// File: rtl/poly_envelope.sv
// poly_envelope: multi-channel ADSR envelope generator. Levels and rates are shared; each channel has its own gate.
// Optional: define POLY_ENVELOPE_HARD_RETRIG_EN to restart every attack from zero instead of legato.
module poly_envelope #(
    parameter int CHANNELS = 4,
    parameter int LVL_W    = 16,
    parameter int FRAC_W   = 16,
    localparam int ACC_W   = LVL_W + FRAC_W
) (
    input  logic                      Sys_clk,
    input  logic                      Env_rst_n,
    input  logic                      Env_ce,
    input  logic                      Syn_tick,
    input  logic [CHANNELS-1:0]       Syn_key,
    input  logic [LVL_W-1:0]          A_lvl,
    input  logic [LVL_W-1:0]          S_lvl,
    input  logic [ACC_W-1:0]          A_rate,
    input  logic [ACC_W-1:0]          D_rate,
    input  logic [ACC_W-1:0]          R_rate,
    output logic [CHANNELS*LVL_W-1:0] Env_lvl,
    output logic [CHANNELS-1:0]       Env_active
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ATTACK  = 3'd1,
        DECAY   = 3'd2,
        SUSTAIN = 3'd3,
        RELEASE = 3'd4
    } state_t;

    logic [ACC_W-1:0] peak;
    logic [ACC_W-1:0] sus;

    assign peak = {A_lvl, {FRAC_W{1'b0}}};
    assign sus  = {S_lvl, {FRAC_W{1'b0}}};

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_chan
            state_t           state_reg, state_next;
            logic [ACC_W-1:0] acc_reg, acc_next, start_acc;
            logic [ACC_W:0]   att_sum, dec_diff, rel_diff;
            logic             key_q_reg;
            logic             rise, fall;
            logic [LVL_W-1:0] lvl_reg;
            logic             active_reg;

            assign rise = Syn_key[gi] & ~key_q_reg;
            assign fall = ~Syn_key[gi] & key_q_reg;

`ifdef POLY_ENVELOPE_HARD_RETRIG_EN
            assign start_acc = '0;
`else
            assign start_acc = acc_reg;
`endif

            // One extra bit catches attack overflow and decay/release borrow.
            assign att_sum  = {1'b0, acc_reg} + {1'b0, A_rate};
            assign dec_diff = {1'b0, acc_reg} - {1'b0, D_rate};
            assign rel_diff = {1'b0, acc_reg} - {1'b0, R_rate};

            always_comb begin
                state_next = state_reg;
                acc_next   = acc_reg;
                if (rise) begin
                    if (start_acc >= peak) begin
                        acc_next   = peak;
                        state_next = DECAY;
                    end else begin
                        acc_next   = start_acc;
                        state_next = ATTACK;
                    end
                end else if (fall && (state_reg == ATTACK || state_reg == DECAY ||
                                      state_reg == SUSTAIN)) begin
                    state_next = RELEASE;
                end else begin
                    case (state_reg)
                        ATTACK: begin
                            if (A_rate == '0 || att_sum >= {1'b0, peak}) begin
                                acc_next   = peak;
                                state_next = DECAY;
                            end else begin
                                acc_next = att_sum[ACC_W-1:0];
                            end
                        end
                        DECAY: begin
                            // A start already at or below sus lands here too, since diff <= acc.
                            if (D_rate == '0 || dec_diff[ACC_W] || dec_diff[ACC_W-1:0] <= sus) begin
                                acc_next   = sus;
                                state_next = SUSTAIN;
                            end else begin
                                acc_next = dec_diff[ACC_W-1:0];
                            end
                        end
                        SUSTAIN: begin
                            acc_next = sus;
                        end
                        RELEASE: begin
                            if (R_rate == '0 || rel_diff[ACC_W] || rel_diff[ACC_W-1:0] == '0) begin
                                acc_next   = '0;
                                state_next = IDLE;
                            end else begin
                                acc_next = rel_diff[ACC_W-1:0];
                            end
                        end
                        default: begin
                            state_next = state_reg;
                        end
                    endcase
                end
            end

            always_ff @(posedge Sys_clk or negedge Env_rst_n) begin
                if (!Env_rst_n) begin
                    state_reg  <= IDLE;
                    acc_reg    <= '0;
                    key_q_reg  <= 1'b0;
                    lvl_reg    <= '0;
                    active_reg <= 1'b0;
                end else if (Env_ce) begin
                    if (Syn_tick) begin
                        state_reg <= state_next;
                        acc_reg   <= acc_next;
                        key_q_reg <= Syn_key[gi];
                    end
                    // Outputs follow the accumulator one edge later.
                    lvl_reg    <= acc_reg[ACC_W-1:FRAC_W];
                    active_reg <= (state_reg != IDLE);
                end
            end

            assign Env_lvl[gi*LVL_W +: LVL_W] = lvl_reg;
            assign Env_active[gi]             = active_reg;
        end
    endgenerate

endmodule
